// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: control bundle type, opcode/ALUOp encodings and the bubble constant
// shared by the pipeline control unit (Rev 1.0).
`default_nettype none

package pipe_ctrl_pkg;

  localparam int CTRL_AW      = 5;
  localparam int CTRL_ALUOP_W = 4;

  typedef struct packed {
    logic                    RegDst;
    logic                    Branch;
    logic                    Bne;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    MemToReg;
    logic                    ALUSrc;
    logic                    RegWrite;
    logic                    Lui;
    logic                    Jump;
    logic                    Link;
    logic                    R31Write;
    logic                    RegToPc;
    logic [CTRL_ALUOP_W-1:0] ALUOp;
    logic [CTRL_AW-1:0]      dst;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLT   = 4'd5;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_LUI   = 4'd6;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_RTYPE = 4'd7;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [CTRL_AW-1:0] a, input logic [CTRL_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational opcode decode into a ctrl_t bundle, with destination
// selection and an undecodable-opcode flag (Rev 1.0).
`default_nettype none

module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output ctrl_t             ctrl,
  output logic              legal
);

  logic [ALUOP_W-1:0] alu_op;

  always_comb begin
    ctrl   = BUBBLE;
    legal  = 1'b1;
    alu_op = '0;
    case (opcode)
      OP_RTYPE: begin ctrl.RegDst = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_RTYPE); end
      OP_ADDI:  begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_ADD); end
      OP_ANDI:  begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_AND); end
      OP_ORI:   begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_OR); end
      OP_XORI:  begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_XOR); end
      OP_SLTI:  begin ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_SLT); end
      OP_LW: begin
        ctrl.MemRead  = 1'b1;
        ctrl.MemToReg = 1'b1;
        ctrl.ALUSrc   = 1'b1;
        ctrl.RegWrite = 1'b1;
        alu_op        = ALUOP_W'(ALU_ADD);
      end
      OP_SW:    begin ctrl.MemWrite = 1'b1; ctrl.ALUSrc = 1'b1; alu_op = ALUOP_W'(ALU_ADD); end
      OP_LUI: begin
        ctrl.Lui = 1'b1; ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1; alu_op = ALUOP_W'(ALU_LUI);
      end
      OP_J:     ctrl.Jump = 1'b1;
      OP_JAL: begin
        ctrl.Jump = 1'b1; ctrl.Link = 1'b1; ctrl.R31Write = 1'b1; ctrl.RegWrite = 1'b1;
      end
      OP_BEQ:   begin ctrl.Branch = 1'b1; alu_op = ALUOP_W'(ALU_SUB); end
      OP_BNE:   begin ctrl.Branch = 1'b1; ctrl.Bne = 1'b1; alu_op = ALUOP_W'(ALU_SUB); end
      default:  legal = 1'b0;
    endcase

    if (legal) begin
      ctrl.ALUOp = CTRL_ALUOP_W'(alu_op);
      if (ctrl.RegDst)        ctrl.dst = CTRL_AW'(rd);
      else if (ctrl.R31Write) ctrl.dst = '1;
      else                    ctrl.dst = CTRL_AW'(rt);
      // A write to r0 is architecturally a no-op; dropping it keeps hazards from matching it.
      if (ctrl.dst == '0) ctrl.RegWrite = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: 5-stage pipeline control (decode, stage bundles, hazards, forwarding).
// Define PIPE_CTRL_FWD_EN to enable EX operand forwarding; otherwise RAW hazards stall (Rev 1.0).
`default_nettype none

module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_taken,
  output ctrl_t             ex_ctrl,
  output ctrl_t             mem_ctrl,
  output ctrl_t             wb_ctrl,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              illegal
);

  ctrl_t dec_ctrl;
  logic  dec_legal;
  ctrl_t ex_ctrl_d, ex_ctrl_q, mem_ctrl_d, mem_ctrl_q, wb_ctrl_d, wb_ctrl_q;
  logic  [CTRL_AW-1:0] id_rs_c, id_rt_c;
  logic  load_use, raw_hazard;

  pipe_ctrl_decode #(
    .REG_AW (REG_AW),
    .ALUOP_W(ALUOP_W)
  ) u_decode (
    .opcode(id_opcode),
    .rt    (id_rt),
    .rd    (id_rd),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

  assign id_rs_c = CTRL_AW'(id_rs);
  assign id_rt_c = CTRL_AW'(id_rt);

  always_comb begin
    load_use = id_valid && ex_ctrl_q.MemRead &&
               (reg_match(ex_ctrl_q.dst, id_rs_c) || reg_match(ex_ctrl_q.dst, id_rt_c));
`ifdef PIPE_CTRL_FWD_EN
    raw_hazard = 1'b0;
`else
    raw_hazard = id_valid &&
                 ((ex_ctrl_q.RegWrite &&
                   (reg_match(ex_ctrl_q.dst, id_rs_c) || reg_match(ex_ctrl_q.dst, id_rt_c))) ||
                  (mem_ctrl_q.RegWrite &&
                   (reg_match(mem_ctrl_q.dst, id_rs_c) || reg_match(mem_ctrl_q.dst, id_rt_c))));
`endif
    flush   = ex_taken;
    stall   = !ex_taken && (load_use || raw_hazard);
    illegal = id_valid && !dec_legal && !ex_taken && !stall;

    ex_ctrl_d  = (id_valid && !ex_taken && !stall) ? dec_ctrl : BUBBLE;
    mem_ctrl_d = ex_ctrl_q;
    wb_ctrl_d  = mem_ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_ctrl_q  <= BUBBLE;
      mem_ctrl_q <= BUBBLE;
      wb_ctrl_q  <= BUBBLE;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  // Source fields only matter to forwarding, so the ID/EX copy of rs/rt lives here.
  logic [CTRL_AW-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q;

  always_comb begin
    ex_rs_d = (ex_ctrl_d == BUBBLE) ? '0 : id_rs_c;
    ex_rt_d = (ex_ctrl_d == BUBBLE) ? '0 : id_rt_c;

    fwd_a = 2'b00;
    if (mem_ctrl_q.RegWrite && reg_match(mem_ctrl_q.dst, ex_rs_q))     fwd_a = 2'b10;
    else if (wb_ctrl_q.RegWrite && reg_match(wb_ctrl_q.dst, ex_rs_q))  fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (mem_ctrl_q.RegWrite && reg_match(mem_ctrl_q.dst, ex_rt_q))     fwd_b = 2'b10;
    else if (wb_ctrl_q.RegWrite && reg_match(wb_ctrl_q.dst, ex_rt_q))  fwd_b = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign ex_ctrl  = ex_ctrl_q;
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit; expectations follow
// PIPE_CTRL_FWD_EN when it is defined, otherwise the stalling build (Rev 1.0).
`default_nettype none

module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, id_valid, ex_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  ctrl_t      ex_ctrl, mem_ctrl, wb_ctrl;
  logic       stall, flush, illegal;
  logic [1:0] fwd_a, fwd_b;
  int         checks = 0;
  int         errors = 0;

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    ex_taken  = 1'b0;
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd);
    @(negedge clk);
    drive(v, op, rs, rt, rd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ex", 32'(ex_ctrl), 32'd0);
    chk("rst_mem", 32'(mem_ctrl), 32'd0);
    chk("rst_wb", 32'(wb_ctrl), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    rst = 1'b1;

    // lw r2 followed by dependent add r3,r2,r4
    step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0);
    chk("lu_no_stall_first", 32'(stall), 32'd0);
    step(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lw_memread", 32'(ex_ctrl.MemRead), 32'd1);
    chk("lw_dst", 32'(ex_ctrl.dst), 32'd2);
    chk("lw_regwrite", 32'(ex_ctrl.RegWrite), 32'd1);
    step(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    chk("lu_ex_bubble", 32'(ex_ctrl), 32'd0);
`ifdef PIPE_CTRL_FWD_EN
    chk("lu_stall_released", 32'(stall), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'b01);
    chk("lu_fwd_b_none", 32'(fwd_b), 32'b00);
`else
    chk("raw_stall_mem", 32'(stall), 32'd1);
    step(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    chk("raw_stall_released", 32'(stall), 32'd0);
    chk("raw_ex_bubble2", 32'(ex_ctrl), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("raw_fwd_a_tied", 32'(fwd_a), 32'b00);
`endif
    chk("add_regdst", 32'(ex_ctrl.RegDst), 32'd1);
    chk("add_dst", 32'(ex_ctrl.dst), 32'd3);
    idle(3);

    // add r5,r1,r1 followed by sub r6,r5,r5
    step(1'b1, OP_RTYPE, 5'd1, 5'd1, 5'd5);
    chk("as_no_stall_first", 32'(stall), 32'd0);
    step(1'b1, OP_RTYPE, 5'd5, 5'd5, 5'd6);
`ifdef PIPE_CTRL_FWD_EN
    chk("as_no_stall", 32'(stall), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("as_fwd_a_mem", 32'(fwd_a), 32'b10);
    chk("as_fwd_b_mem", 32'(fwd_b), 32'b10);
`else
    chk("as_stall_1", 32'(stall), 32'd1);
    step(1'b1, OP_RTYPE, 5'd5, 5'd5, 5'd6);
    chk("as_stall_2", 32'(stall), 32'd1);
    step(1'b1, OP_RTYPE, 5'd5, 5'd5, 5'd6);
    chk("as_stall_done", 32'(stall), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("as_fwd_a_tied", 32'(fwd_a), 32'b00);
    chk("as_fwd_b_tied", 32'(fwd_b), 32'b00);
`endif
    chk("sub_dst", 32'(ex_ctrl.dst), 32'd6);
    idle(3);

    // taken branch resolves while a load-use hazard sits in ID
    step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0);
    step(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    ex_taken = 1'b1;
    #1;
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_stall_suppressed", 32'(stall), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("br_ex_bubble", 32'(ex_ctrl), 32'd0);
    chk("br_mem_lw", 32'(mem_ctrl.MemRead), 32'd1);
    chk("br_flush_drop", 32'(flush), 32'd0);
    idle(3);

    // undecodable opcode
    step(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
    chk("ill_pulse", 32'(illegal), 32'd1);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("ill_ex_bubble", 32'(ex_ctrl), 32'd0);

    // jal reaches WB three cycles after issue
    step(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("jal_jump", 32'(ex_ctrl.Jump), 32'd1);
    chk("jal_link", 32'(ex_ctrl.Link), 32'd1);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("jal_wb_dst", 32'(wb_ctrl.dst), 32'd31);
    chk("jal_wb_regwrite", 32'(wb_ctrl.RegWrite), 32'd1);

    // addi to r0 never writes and never matches
    step(1'b1, OP_ADDI, 5'd3, 5'd0, 5'd0);
    step(1'b1, OP_RTYPE, 5'd0, 5'd0, 5'd7);
    chk("addi_r0_regwrite", 32'(ex_ctrl.RegWrite), 32'd0);
    chk("addi_r0_alusrc", 32'(ex_ctrl.ALUSrc), 32'd1);
    chk("r0_no_stall", 32'(stall), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("r0_fwd_a", 32'(fwd_a), 32'b00);
    chk("r0_fwd_b", 32'(fwd_b), 32'b00);

    // bne decode
    step(1'b1, OP_BNE, 5'd1, 5'd2, 5'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("bne_branch", 32'(ex_ctrl.Branch), 32'd1);
    chk("bne_bne", 32'(ex_ctrl.Bne), 32'd1);
    chk("bne_aluop", 32'(ex_ctrl.ALUOp), 32'(ALU_SUB));
    chk("bne_regwrite", 32'(ex_ctrl.RegWrite), 32'd0);
    idle(3);

    // reset asserted during a stall cycle
    step(1'b1, OP_LW, 5'd1, 5'd2, 5'd0);
    step(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    rst = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, OP_RTYPE, 5'd2, 5'd4, 5'd3);
    #1;
    chk("post_rst_ex", 32'(ex_ctrl), 32'd0);
    chk("post_rst_mem", 32'(mem_ctrl), 32'd0);
    chk("post_rst_wb", 32'(wb_ctrl), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_flush", 32'(flush), 32'd0);
    chk("post_rst_illegal", 32'(illegal), 32'd0);
    chk("post_rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("post_rst_fwd_b", 32'(fwd_b), 32'd0);
    step(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    chk("post_rst_add_issued", 32'(ex_ctrl.dst), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
